// File: rtl/line_buf_win3_ctrl.sv
// ---------------------------------------------------------------------------
// line_buf_win3_ctrl
//
// Sequences two external 1-bit line FIFOs into a 3-row vertical window for
// the binary erosion/dilation stage.
//
//   * FIFO0 holds the previous line (y-1).
//   * FIFO1 holds the line before that (y-2).
//   * FIFO0 is cascaded into FIFO1 one clock after each read, because the
//     read data appears one clock after rd_en.
//   * Once lines 0 and 1 have been loaded, every accepted pixel yields one
//     window column one clock later. The column holds top (y-2), mid (y-1)
//     and bot (y).
//   * After the last pixel of a frame, or after a misplaced sof, the block
//     drains both FIFOs empty before it accepts a new frame.
//
// Optional feature: define LBW_FRAME_CNT_EN to add the frame_cnt[15:0]
// output. It counts frames that completed cleanly.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_data/in_sof    pixel stream in, in_ready = accept
//   f0_*/f1_* wr_en, wr_data   FIFO write side (driven)
//   f0_*/f1_* rd_en            FIFO read request (driven)
//   f0_*/f1_* rd_data          FIFO read data, valid 1 clk after rd_en
//   f0_*/f1_* empty, full      FIFO status flags
//   out_valid, out_top/mid/bot window column; out_x column, out_y line of bot
//   err                        sticky protocol error, cleared only by rst
//   frame_cnt                  (LBW_FRAME_CNT_EN only) clean frame count
// ---------------------------------------------------------------------------
module line_buf_win3_ctrl #(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic             in_sof,
  output logic             in_ready,
  output logic             f0_wr_en,
  output logic             f1_wr_en,
  output logic             f0_wr_data,
  output logic             f1_wr_data,
  output logic             f0_rd_en,
  output logic             f1_rd_en,
  input  logic             f0_rd_data,
  input  logic             f1_rd_data,
  input  logic             f0_empty,
  input  logic             f1_empty,
  input  logic             f0_full,
  input  logic             f1_full,
  output logic             out_valid,
  output logic             out_top,
  output logic             out_mid,
  output logic             out_bot,
  output logic [CNT_W-1:0] out_x,
  output logic [CNT_W-1:0] out_y,
`ifdef LBW_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             err
);

  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL0 = 3'd1,
    ST_FILL1 = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t           state_r, state_nxt;
  state_t           eff_state_s;
  logic [CNT_W-1:0] col_r, col_nxt, line_r, line_nxt;
  logic [CNT_W-1:0] cur_col_s, cur_line_s;
  logic             accept_s, proc_s, sof_err_s, last_col_s;
  logic             run_proc_s, frame_end_s, drain_done_s, err_evt_s;
  logic             f0_rd_en_s, f1_rd_en_s, f0_wr_en_s, f1_wr_en_s;
  logic             f1_wr_pend_r;
  logic             out_valid_r, bot_r, err_r;
  logic [CNT_W-1:0] x_r, y_r;
`ifdef LBW_FRAME_CNT_EN
  logic [15:0]      frame_cnt_r;
  logic             clean_r;
`endif

  // Accept decode. Classifies the current pixel and picks the state it
  // belongs to. A sof accepted in IDLE is already pixel (0,0) of FILL0.
  always_comb begin
    accept_s    = in_valid & (state_r != ST_DRAIN);
    sof_err_s   = 1'b0;
    proc_s      = 1'b0;
    eff_state_s = state_r;
    cur_col_s   = col_r;
    cur_line_s  = line_r;
    case (state_r)
      ST_IDLE: begin
        proc_s      = accept_s & in_sof;
        eff_state_s = in_sof ? ST_FILL0 : ST_IDLE;
        cur_col_s   = {CNT_W{1'b0}};
        cur_line_s  = {CNT_W{1'b0}};
      end
      ST_FILL0, ST_FILL1, ST_RUN: begin
        proc_s    = accept_s & ~in_sof;
        sof_err_s = accept_s & in_sof;
      end
      ST_DRAIN: begin
        proc_s = 1'b0;
      end
      default: begin
        proc_s      = 1'b0;
        eff_state_s = ST_IDLE;
      end
    endcase
    last_col_s   = (cur_col_s == LAST_COL);
    run_proc_s   = proc_s & (eff_state_s == ST_RUN);
    frame_end_s  = run_proc_s & last_col_s & (cur_line_s == LAST_LINE);
    // A cascade write may still be in flight into FIFO1, so its empty flag
    // alone is not final.
    drain_done_s = f0_empty & f1_empty & ~f1_wr_pend_r;
  end

  // FIFO strobes. Window reads are never suppressed. Drain reads only
  // target FIFOs that still hold data.
  always_comb begin
    f0_wr_en_s = proc_s;
    f1_wr_en_s = f1_wr_pend_r;
    if (state_r == ST_DRAIN) begin
      f0_rd_en_s = ~f0_empty;
      f1_rd_en_s = ~f1_empty;
    end else begin
      f0_rd_en_s = proc_s & ((eff_state_s == ST_FILL1) | (eff_state_s == ST_RUN));
      f1_rd_en_s = run_proc_s;
    end
    err_evt_s = sof_err_s
              | (f0_rd_en_s & f0_empty) | (f1_rd_en_s & f1_empty)
              | (f0_wr_en_s & f0_full)  | (f1_wr_en_s & f1_full);
  end

  // Next-state and counter logic. Line end and state change share one edge.
  always_comb begin
    state_nxt = state_r;
    col_nxt   = col_r;
    line_nxt  = line_r;
    case (state_r)
      ST_IDLE, ST_FILL0, ST_FILL1, ST_RUN: begin
        if (sof_err_s) begin
          state_nxt = ST_DRAIN;
          col_nxt   = {CNT_W{1'b0}};
          line_nxt  = {CNT_W{1'b0}};
        end else if (proc_s) begin
          if (last_col_s) begin
            col_nxt = {CNT_W{1'b0}};
            case (eff_state_s)
              ST_FILL0: begin
                state_nxt = ST_FILL1;
                line_nxt  = cur_line_s + CNT_W'(1);
              end
              ST_FILL1: begin
                state_nxt = ST_RUN;
                line_nxt  = cur_line_s + CNT_W'(1);
              end
              ST_RUN: begin
                if (frame_end_s) begin
                  state_nxt = ST_DRAIN;
                  line_nxt  = {CNT_W{1'b0}};
                end else begin
                  state_nxt = ST_RUN;
                  line_nxt  = cur_line_s + CNT_W'(1);
                end
              end
              default: begin
                state_nxt = ST_IDLE;
                line_nxt  = {CNT_W{1'b0}};
              end
            endcase
          end else begin
            state_nxt = eff_state_s;
            col_nxt   = cur_col_s + CNT_W'(1);
            line_nxt  = cur_line_s;
          end
        end else begin
          state_nxt = state_r;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_nxt = ST_IDLE;
          col_nxt   = {CNT_W{1'b0}};
          line_nxt  = {CNT_W{1'b0}};
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        col_nxt   = {CNT_W{1'b0}};
        line_nxt  = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counters, cascade pending flag, output column register, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      col_r        <= {CNT_W{1'b0}};
      line_r       <= {CNT_W{1'b0}};
      f1_wr_pend_r <= 1'b0;
      out_valid_r  <= 1'b0;
      bot_r        <= 1'b0;
      x_r          <= {CNT_W{1'b0}};
      y_r          <= {CNT_W{1'b0}};
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      col_r        <= col_nxt;
      line_r       <= line_nxt;
      // Each FIFO0 read in FILL1/RUN is forwarded to FIFO1 when its data lands.
      f1_wr_pend_r <= proc_s & ((eff_state_s == ST_FILL1) | (eff_state_s == ST_RUN));
      out_valid_r  <= run_proc_s;
      bot_r        <= run_proc_s & in_data;
      if (run_proc_s) begin
        x_r <= cur_col_s;
        y_r <= cur_line_s;
      end else begin
        x_r <= x_r;
        y_r <= y_r;
      end
      err_r        <= err_r | err_evt_s;
    end
  end

`ifdef LBW_FRAME_CNT_EN
  // Clean-frame counter. A drain entered through a sof error does not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 16'd0;
      clean_r     <= 1'b0;
    end else begin
      if (frame_end_s) begin
        clean_r <= 1'b1;
      end else if (sof_err_s) begin
        clean_r <= 1'b0;
      end else if ((state_r == ST_DRAIN) && drain_done_s) begin
        clean_r <= 1'b0;
      end else begin
        clean_r <= clean_r;
      end
      if ((state_r == ST_DRAIN) && drain_done_s && clean_r) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

  assign in_ready   = (state_r != ST_DRAIN);
  assign f0_wr_en   = f0_wr_en_s;
  assign f0_wr_data = proc_s & in_data;
  assign f1_wr_en   = f1_wr_en_s;
  assign f1_wr_data = f1_wr_pend_r & f0_rd_data;
  assign f0_rd_en   = f0_rd_en_s;
  assign f1_rd_en   = f1_rd_en_s;
  // Top and mid come straight from FIFO read data, which is valid in the
  // output cycle. They are gated so that idle cycles show 0.
  assign out_valid  = out_valid_r;
  assign out_top    = out_valid_r & f1_rd_data;
  assign out_mid    = out_valid_r & f0_rd_data;
  assign out_bot    = bot_r;
  assign out_x      = x_r;
  assign out_y      = y_r;
  assign err        = err_r;

endmodule
